sdram_uart_dumper: RTL

Readback stage between the SDRAM controller and the AVR serial interface. After a capture completes, it reads a block of 32-bit pixel words from SDRAM and streams them to the host through the `avr_interface` byte-transmit handshake. Each block is framed with a header byte and a trailing XOR checksum byte. It shares the SDRAM port with the capture logic and drives it only while `active` is high.

---
 rtl/jg_dump_pkg.sv | 18 +
 rtl/sdram_uart_dumper_if.sv | 25 ++
 rtl/tx_byte_pacer.sv | 28 ++
 rtl/sdram_uart_dumper.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/jg_dump_pkg.sv
// Shared types and constants for the SDRAM-to-UART readback dumper.
package jg_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_CSUM,
    S_FIN
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         LANES          = 4;
  localparam int         LANE_W         = $clog2(LANES);

endpackage

// File: rtl/sdram_uart_dumper_if.sv
// SDRAM command/read port plus the AVR byte-transmit handshake, seen from the dumper (master).
interface sdram_uart_dumper_if #(
  parameter int ADDR_W = 23
);
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [31:0]       data_in;
  logic              in_valid;
  logic              busy;
  logic [31:0]       data_out;
  logic              out_valid;
  logic [7:0]        tx_data;
  logic              new_tx_data;
  logic              tx_busy;

  modport master (
    output addr, rw, data_in, in_valid, tx_data, new_tx_data,
    input  busy, data_out, out_valid, tx_busy
  );

  modport slave (
    input  addr, rw, data_in, in_valid, tx_data, new_tx_data,
    output busy, data_out, out_valid, tx_busy
  );
endinterface

// File: rtl/tx_byte_pacer.sv
// Issues one registered byte strobe per accepted send, then holds the byte through a gap cycle.
module tx_byte_pacer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] send_byte,
  output logic       ready,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       new_tx_data
);

  // tx_busy lags the strobe by a cycle, so it is ignored while the strobe is high;
  // the following (gap) cycle is the first one where it is trusted again.
  assign ready = !new_tx_data && !tx_busy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_tx_data <= 1'b0;
      tx_data     <= '0;
    end else begin
      new_tx_data <= send && ready;
      if (send && ready) tx_data <= send_byte;
    end
  end

endmodule

// File: rtl/sdram_uart_dumper.sv
// Reads a block of 32-bit words from SDRAM and streams header, little-endian bytes and an XOR checksum.
module sdram_uart_dumper
  import jg_dump_pkg::*;
#(
  parameter int         ADDR_W = 23,
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    word_count,
  output logic                 active,
  output logic                 done,
  sdram_uart_dumper_if.master  bus
);

  state_t              state;
  logic [ADDR_W-1:0]   remaining;
  logic [31:0]         shreg;
  logic [7:0]          csum;
  logic [LANE_W-1:0]   lane;

  logic       send;
  logic [7:0] send_byte;
  logic       ready;
  logic       accept;
  logic [7:0] tx_byte;
  logic       tx_strobe;

  assign bus.rw          = 1'b0;
  assign bus.data_in     = '0;
  assign bus.tx_data     = tx_byte;
  assign bus.new_tx_data = tx_strobe;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    send      = 1'b0;
    send_byte = '0;
    case (state)
      S_HDR:  begin send = 1'b1; send_byte = HEADER;      end
      S_SEND: begin send = 1'b1; send_byte = shreg[7:0];  end
      S_CSUM: begin send = 1'b1; send_byte = csum;        end
      default: ;
    endcase
  end

  assign accept = send && ready;

  tx_byte_pacer u_pacer (
    .clk         (clk),
    .rst_n       (rst_n),
    .send        (send),
    .send_byte   (send_byte),
    .ready       (ready),
    .tx_busy     (bus.tx_busy),
    .tx_data     (tx_byte),
    .new_tx_data (tx_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      active       <= 1'b0;
      done         <= 1'b0;
      bus.addr     <= '0;
      bus.in_valid <= 1'b0;
      remaining    <= '0;
      shreg        <= '0;
      csum         <= '0;
      lane         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A start landing on the done pulse belongs to the finished dump and is dropped.
          if (start && !done) begin
            bus.addr  <= base_addr;
            remaining <= word_count;
            csum      <= '0;
            active    <= 1'b1;
            state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (accept) begin
            if (remaining == '0) begin
              state <= S_CSUM;
            end else begin
              bus.in_valid <= 1'b1;
              state        <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (!bus.busy) begin
            bus.in_valid <= 1'b0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.out_valid) begin
            shreg <= bus.data_out;
            lane  <= '0;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (accept) begin
            csum  <= csum ^ shreg[7:0];
            shreg <= {8'h00, shreg[31:8]};
            lane  <= lane + 1'b1;
            if (lane == LANE_W'(LANES - 1)) begin
              bus.addr  <= bus.addr + ADDR_W'(1);
              remaining <= remaining - ADDR_W'(1);
              if (remaining == ADDR_W'(1)) begin
                state <= S_CSUM;
              end else begin
                bus.in_valid <= 1'b1;
                state        <= S_REQ;
              end
            end
          end
        end
        S_CSUM: begin
          if (accept) state <= S_FIN;
        end
        S_FIN: begin
          // Wait out the checksum strobe so done lands after its gap cycle.
          if (!tx_strobe) begin
            done   <= 1'b1;
            active <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
